// File: rtl/btb_pkg.sv
// Shared types for the BTB port scheduler: default index width, tag width,
// table entry layout, queued update record and scheduler state.
package btb_pkg;

    localparam int IDX_W_DEF = 6;
    localparam int TAG_W     = 30 - IDX_W_DEF;

    // One BTB table entry as stored in the array.
    typedef struct packed {
        logic             valid;
        logic             taken;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

    // One resolved-branch update waiting for the table port.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } upd_req_t;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Index-coalescing update queue. A push whose table index matches a resident
// entry (other than a head that is leaving this cycle) overwrites that entry
// in place; otherwise it appends. Full/empty use one extra pointer bit.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int QDEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     clear,
    input  logic     push,
    input  upd_req_t push_data,
    input  logic     pop,
    output upd_req_t head,
    output logic     full,
    output logic     empty,
    output logic     coalesce
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] rd_slot;
    logic [PTR_W-1:0] wr_slot;
    logic [PTR_W-1:0] hit_slot;
    logic             hit;
    upd_req_t         mem [QDEPTH];

    assign rd_slot  = rd_ptr[PTR_W-1:0];
    assign wr_slot  = wr_ptr[PTR_W-1:0];
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (count == (PTR_W+1)'(QDEPTH));
    assign head     = mem[rd_slot];
    assign coalesce = push && hit;

    // Find a resident entry with the pushed index that is not being popped.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        hit      = 1'b0;
        hit_slot = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (({1'b0, PTR_W'(i) - rd_slot} < count) &&
                (mem[i].pc[IDX_W+1:2] == push_data.pc[IDX_W+1:2]) &&
                !(pop && (PTR_W'(i) == rd_slot))) begin
                hit      = 1'b1;
                hit_slot = PTR_W'(i);
            end
        end
    end

    // Entry storage: overwrite the matching slot or fill the tail slot.
    // NOTE: storage has no reset; which slots are live is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[hit ? hit_slot : wr_slot] <= push_data;
        end
    end

    // Pointer update; clear (flush) wins over a same-cycle push or pop.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !hit) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)          rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/btb_port_sched.sv
// Single-port BTB scheduler: clear sweep after reset/flush, then per-cycle
// arbitration between fetch lookups and queued branch updates with a
// starvation limit on lookups. Optional counters under BTB_SCHED_STATS_EN.
module btb_port_sched
    import btb_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              lkp_req_i,
    input  logic [31:0]       lkp_pc_i,
    output logic              lkp_gnt_o,
    output logic              lkp_rvalid_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic [31:0]       upd_target_i,
    input  logic              upd_taken_i,
    output logic              upd_ready_o,
    output logic              busy_o,
    output logic              tbl_en_o,
    output logic              tbl_we_o,
    output logic [IDX_W-1:0]  tbl_addr_o,
    output logic [63-IDX_W:0] tbl_wdata_o
`ifdef BTB_SCHED_STATS_EN
    ,
    output logic [31:0]       wr_cnt_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       coal_cnt_o
`endif
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t           state, next_state;
    logic [IDX_W-1:0] sweep, next_sweep;
    logic [SW-1:0]    starve;
    logic             gnt_dly;
    logic             push, pop;
    logic             q_full, q_empty, q_coalesce;
    upd_req_t         q_head, upd_req;

    assign upd_req = '{pc: upd_pc_i, target: upd_target_i, taken: upd_taken_i};
    assign push    = upd_valid_i && upd_ready_o;

    btb_upd_fifo #(
        .IDX_W  (IDX_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (flush_i),
        .push      (push),
        .push_data (upd_req),
        .pop       (pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .coalesce  (q_coalesce)
    );

    // Next state, sweep address and port arbitration; reset forces outputs low.
    always_comb begin
        next_state  = state;
        next_sweep  = sweep;
        pop         = 1'b0;
        lkp_gnt_o   = 1'b0;
        upd_ready_o = 1'b0;
        busy_o      = 1'b0;
        tbl_en_o    = 1'b0;
        tbl_we_o    = 1'b0;
        tbl_addr_o  = '0;
        tbl_wdata_o = '0;
        case (state)
            CLEAR: begin
                busy_o     = 1'b1;
                tbl_en_o   = 1'b1;
                tbl_we_o   = 1'b1;
                tbl_addr_o = sweep;
                if (flush_i) begin
                    next_sweep = '0;
                end else if (sweep == '1) begin
                    next_state = RUN;
                    next_sweep = '0;
                end else begin
                    next_sweep = sweep + IDX_W'(1);
                end
            end
            RUN: begin
                upd_ready_o = !q_full;
                if (lkp_req_i && (starve < STARVE_LIM)) begin
                    tbl_en_o   = 1'b1;
                    tbl_addr_o = lkp_pc_i[IDX_W+1:2];
                    lkp_gnt_o  = 1'b1;
                end else if (!q_empty) begin
                    tbl_en_o    = 1'b1;
                    tbl_we_o    = 1'b1;
                    tbl_addr_o  = q_head.pc[IDX_W+1:2];
                    tbl_wdata_o = {1'b1, q_head.taken, q_head.pc[31:IDX_W+2], q_head.target};
                    pop         = 1'b1;
                end
                if (flush_i) begin
                    next_state = CLEAR;
                    next_sweep = '0;
                end
            end
            default: next_state = CLEAR;
        endcase
        if (rst_i) begin
            pop         = 1'b0;
            lkp_gnt_o   = 1'b0;
            upd_ready_o = 1'b0;
            busy_o      = 1'b0;
            tbl_en_o    = 1'b0;
            tbl_we_o    = 1'b0;
            tbl_addr_o  = '0;
            tbl_wdata_o = '0;
        end
    end

    // State, sweep counter, starvation counter and read-valid delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            sweep   <= '0;
            starve  <= '0;
            gnt_dly <= 1'b0;
        end else begin
            state   <= next_state;
            sweep   <= next_sweep;
            gnt_dly <= lkp_gnt_o;
            if (flush_i || pop || q_empty || (state == CLEAR)) begin
                starve <= '0;
            end else if (lkp_gnt_o && (starve < STARVE_LIM)) begin
                starve <= starve + SW'(1);
            end
        end
    end

    assign lkp_rvalid_o = gnt_dly && !rst_i;

`ifdef BTB_SCHED_STATS_EN
    logic [31:0] wr_cnt, stall_cnt, coal_cnt;

    // Event counters; only reset clears them, they wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt    <= '0;
            stall_cnt <= '0;
            coal_cnt  <= '0;
        end else begin
            if (pop)                     wr_cnt    <= wr_cnt + 32'd1;
            if (lkp_req_i && !lkp_gnt_o) stall_cnt <= stall_cnt + 32'd1;
            if (q_coalesce && !flush_i)  coal_cnt  <= coal_cnt + 32'd1;
        end
    end

    assign wr_cnt_o    = rst_i ? '0 : wr_cnt;
    assign stall_cnt_o = rst_i ? '0 : stall_cnt;
    assign coal_cnt_o  = rst_i ? '0 : coal_cnt;
`endif

endmodule

// File: tb/tb_btb_port_sched.sv
// Bench for btb_port_sched: directed table vectors, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
// Counter outputs are checked when BTB_SCHED_STATS_EN is defined.
module tb_btb_port_sched;
    import btb_pkg::*;

    localparam int IW   = IDX_W_DEF;
    localparam int QD   = 4;
    localparam int SMAX = 8;
    localparam int NENT = 1 << IW;
    localparam int EW   = 64 - IW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          lkp_req_i = 1'b0;
    logic [31:0]   lkp_pc_i = '0;
    logic          upd_valid_i = 1'b0;
    logic [31:0]   upd_pc_i = '0;
    logic [31:0]   upd_target_i = '0;
    logic          upd_taken_i = 1'b0;
    logic          lkp_gnt_o, lkp_rvalid_o, upd_ready_o, busy_o, tbl_en_o, tbl_we_o;
    logic [IW-1:0] tbl_addr_o;
    logic [EW-1:0] tbl_wdata_o;
`ifdef BTB_SCHED_STATS_EN
    logic [31:0]   wr_cnt_o, stall_cnt_o, coal_cnt_o;
`endif

    btb_port_sched #(.IDX_W(IW), .QDEPTH(QD), .STARVE_MAX(SMAX)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .lkp_req_i    (lkp_req_i),
        .lkp_pc_i     (lkp_pc_i),
        .lkp_gnt_o    (lkp_gnt_o),
        .lkp_rvalid_o (lkp_rvalid_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_target_i (upd_target_i),
        .upd_taken_i  (upd_taken_i),
        .upd_ready_o  (upd_ready_o),
        .busy_o       (busy_o),
        .tbl_en_o     (tbl_en_o),
        .tbl_we_o     (tbl_we_o),
        .tbl_addr_o   (tbl_addr_o),
        .tbl_wdata_o  (tbl_wdata_o)
`ifdef BTB_SCHED_STATS_EN
        ,
        .wr_cnt_o     (wr_cnt_o),
        .stall_cnt_o  (stall_cnt_o),
        .coal_cnt_o   (coal_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_clear = 1'b1;
    int          m_sweep = 0;
    int          m_starve = 0;
    bit          m_prev_gnt = 1'b0;
    upd_req_t    mq[$];
    int unsigned m_wr = 0, m_stall = 0, m_coal = 0;

    // Last observed DUT outputs
    logic          obs_en, obs_we, obs_gnt, obs_rvalid, obs_ready, obs_busy;
    logic [IW-1:0] obs_addr;
    logic [EW-1:0] obs_wdata;

    typedef struct {
        bit            req;
        logic [31:0]   lpc;
        bit            uv;
        logic [31:0]   upc;
        logic [31:0]   utgt;
        bit            utk;
        bit            e_en, e_we, e_gnt, e_rvalid, e_ready;
        logic [IW-1:0] e_addr;
        logic [EW-1:0] e_wdata;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] entry_of(input upd_req_t r);
        btb_entry_t e;
        e.valid  = 1'b1;
        e.taken  = r.taken;
        e.tag    = r.pc[31:IW+2];
        e.target = r.target;
        return e;
    endfunction

    // One clock: compare DUT outputs with the model at negedge, then advance the model.
    task automatic step();
        bit            e_en, e_we, e_gnt, e_rvalid, e_ready, e_busy;
        logic [IW-1:0] e_addr;
        logic [EW-1:0] e_wdata;
        bit            grant, wr, accept;
        int            k;
        upd_req_t      r;
        @(negedge clk_i);
        e_en = 0; e_we = 0; e_gnt = 0; e_rvalid = 0; e_ready = 0; e_busy = 0;
        e_addr = '0; e_wdata = '0;
        if (!rst_i) begin
            e_rvalid = m_prev_gnt;
            if (m_clear) begin
                e_en = 1; e_we = 1; e_busy = 1; e_addr = IW'(m_sweep);
            end else begin
                e_ready = (mq.size() < QD);
                if (lkp_req_i && m_starve < SMAX) begin
                    e_en = 1; e_gnt = 1; e_addr = lkp_pc_i[IW+1:2];
                end else if (mq.size() > 0) begin
                    e_en = 1; e_we = 1; e_addr = mq[0].pc[IW+1:2];
                    e_wdata = entry_of(mq[0]);
                end
            end
        end
        obs_en = tbl_en_o; obs_we = tbl_we_o; obs_gnt = lkp_gnt_o; obs_rvalid = lkp_rvalid_o;
        obs_ready = upd_ready_o; obs_busy = busy_o; obs_addr = tbl_addr_o; obs_wdata = tbl_wdata_o;
        check("tbl_en", obs_en, e_en);
        check("tbl_we", obs_we, e_we);
        check("lkp_gnt", obs_gnt, e_gnt);
        check("lkp_rvalid", obs_rvalid, e_rvalid);
        check("upd_ready", obs_ready, e_ready);
        check("busy", obs_busy, e_busy);
        check("tbl_addr", obs_addr, e_addr);
        check("tbl_wdata", obs_wdata, e_wdata);
`ifdef BTB_SCHED_STATS_EN
        check("wr_cnt", wr_cnt_o, rst_i ? 0 : m_wr);
        check("stall_cnt", stall_cnt_o, rst_i ? 0 : m_stall);
        check("coal_cnt", coal_cnt_o, rst_i ? 0 : m_coal);
`endif
        @(posedge clk_i);
        if (rst_i) begin
            m_clear = 1; m_sweep = 0; m_starve = 0; m_prev_gnt = 0;
            mq.delete(); m_wr = 0; m_stall = 0; m_coal = 0;
        end else begin
            grant  = !m_clear && lkp_req_i && (m_starve < SMAX);
            wr     = !m_clear && !grant && (mq.size() > 0);
            accept = !m_clear && upd_valid_i && (mq.size() < QD);
            m_prev_gnt = grant;
            if (lkp_req_i && !grant) m_stall++;
            if (wr) m_wr++;
            if (m_clear) begin
                if (flush_i)                 m_sweep = 0;
                else if (m_sweep == NENT-1)  begin m_clear = 0; m_sweep = 0; end
                else                         m_sweep++;
            end else if (flush_i) begin
                mq.delete(); m_clear = 1; m_sweep = 0; m_starve = 0;
            end else begin
                if (wr || mq.size() == 0)          m_starve = 0;
                else if (grant && m_starve < SMAX) m_starve++;
                if (wr) void'(mq.pop_front());
                if (accept) begin
                    r = '{pc: upd_pc_i, target: upd_target_i, taken: upd_taken_i};
                    k = -1;
                    foreach (mq[i]) if (mq[i].pc[IW+1:2] == upd_pc_i[IW+1:2]) k = i;
                    if (k >= 0) begin mq[k] = r; m_coal++; end
                    else mq.push_back(r);
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit req, input logic [31:0] lpc, input bit uv,
                         input logic [31:0] upc, input logic [31:0] utgt, input bit utk);
        lkp_req_i = req; lkp_pc_i = lpc; upd_valid_i = uv;
        upd_pc_i = upc; upd_target_i = utgt; upd_taken_i = utk;
    endtask

    initial begin
        int grants, writes, busy_n, data_wr;
        bit wrote, accepted;
        logic [EW-1:0] last_wd;
        logic [NENT-1:0] mask, exp_mask;

        tbl[0] = '{req:0, lpc:32'h0, uv:1, upc:32'h104, utgt:32'h200, utk:1,
                   e_en:0, e_we:0, e_gnt:0, e_rvalid:0, e_ready:1, e_addr:'0, e_wdata:'0};
        tbl[1] = '{req:0, lpc:32'h0, uv:0, upc:32'h0, utgt:32'h0, utk:0,
                   e_en:1, e_we:1, e_gnt:0, e_rvalid:0, e_ready:1, e_addr:6'h01,
                   e_wdata:{1'b1, 1'b1, 24'h000001, 32'h0000_0200}};
        tbl[2] = '{req:1, lpc:32'h0000_00F0, uv:0, upc:32'h0, utgt:32'h0, utk:0,
                   e_en:1, e_we:0, e_gnt:1, e_rvalid:0, e_ready:1, e_addr:6'h3C, e_wdata:'0};
        tbl[3] = '{req:0, lpc:32'h0, uv:0, upc:32'h0, utgt:32'h0, utk:0,
                   e_en:0, e_we:0, e_gnt:0, e_rvalid:1, e_ready:1, e_addr:'0, e_wdata:'0};

        // Reset: all outputs low (checked by step against the model)
        #1;
        drive(1, 32'h40, 1, 32'h104, 32'h1, 1);
        step();
        step();
        check("reset_busy", obs_busy, 0);

        // Clear sweep after reset: 64 writes of zero, lookups refused
        rst_i = 0;
        drive(1, 32'h0000_0040, 0, 0, 0, 0);
        for (int i = 0; i < NENT; i++) begin
            step();
            if (i == 0 || i == NENT-1) begin
                check("sweep_busy", obs_busy, 1);
                check("sweep_addr", obs_addr, i);
                check("sweep_nogrant", obs_gnt, 0);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("run_after_sweep", obs_busy, 0);

        // Directed table vectors
        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].lpc, tbl[i].uv, tbl[i].upc, tbl[i].utgt, tbl[i].utk);
            step();
            check("vec_en", obs_en, tbl[i].e_en);
            check("vec_we", obs_we, tbl[i].e_we);
            check("vec_gnt", obs_gnt, tbl[i].e_gnt);
            check("vec_rvalid", obs_rvalid, tbl[i].e_rvalid);
            check("vec_ready", obs_ready, tbl[i].e_ready);
            check("vec_addr", obs_addr, tbl[i].e_addr);
            check("vec_wdata", obs_wdata, tbl[i].e_wdata);
        end

        // Starvation limit: 8 grants with the queue occupied, then one write
        drive(1, $urandom, 1, 32'h208, 32'h1000, 0);
        step();
        grants = 0; wrote = 0;
        for (int i = 0; i < 20 && !wrote; i++) begin
            drive(1, $urandom, 0, 0, 0, 0);
            step();
            if (obs_we) wrote = 1;
            else if (obs_gnt) grants++;
        end
        check("starve_grants", grants, SMAX);
        check("starve_write", wrote, 1);
        step();
        check("lookup_resumes", obs_gnt, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("rvalid_after_grant", obs_rvalid, 1);

        // Coalescing: same index, different tag while lookups block
        drive(1, $urandom, 1, 32'h104, 32'h300, 0);
        step();
        drive(1, $urandom, 1, 32'h504, 32'h400, 1);
        step();
        writes = 0; last_wd = '0;
        for (int i = 0; i < 15; i++) begin
            drive(i < 12, $urandom, 0, 0, 0, 0);
            step();
            if (obs_we) begin writes++; last_wd = obs_wdata; end
        end
        check("coal_writes", writes, 1);
        check("coal_wdata", last_wd, {1'b1, 1'b1, 24'h000005, 32'h0000_0400});
`ifdef BTB_SCHED_STATS_EN
        check("coal_cnt_one", coal_cnt_o, 1);
`endif

        // Fill four distinct indices, hold a fifth until a slot frees
        writes = 0; mask = '0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, $urandom, 1, 32'(i * 16), 32'(i), 1);
            step();
            if (obs_we) begin writes++; mask[obs_addr] = 1'b1; end
        end
        drive(1, $urandom, 1, 32'h50, 32'h5, 0);
        step();
        check("full_ready", obs_ready, 0);
        if (obs_we) begin writes++; mask[obs_addr] = 1'b1; end
        accepted = 0;
        for (int i = 0; i < 30 && !accepted; i++) begin
            step();
            if (obs_we) begin writes++; mask[obs_addr] = 1'b1; end
            if (obs_ready) accepted = 1;
        end
        check("fifth_accepted", accepted, 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            step();
            if (obs_we) begin writes++; mask[obs_addr] = 1'b1; end
        end
        exp_mask = '0;
        for (int i = 1; i <= 5; i++) exp_mask[i*4] = 1'b1;
        check("fill_writes", writes, 5);
        check("fill_addrs", mask, exp_mask);

        // Flush with three entries queued: none of them is written
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom, 1, 32'h60 + 32'(i * 4), 32'hABC0 + 32'(i), 1);
            step();
        end
        drive(1, $urandom, 0, 0, 0, 0);
        flush_i = 1;
        step();
        check("flush_cycle_grant", obs_gnt, 1);
        flush_i = 0;
        drive(0, 0, 0, 0, 0, 0);
        busy_n = 0; data_wr = 0;
        for (int i = 0; i < NENT + 10; i++) begin
            step();
            if (i == 0) check("busy_after_flush", obs_busy, 1);
            if (obs_busy) busy_n++;
            if (obs_we && obs_wdata != '0) data_wr++;
        end
        check("flush_sweep_len", busy_n, NENT);
        check("flush_no_stale_write", data_wr, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            flush_i     = ($urandom_range(0, 199) == 0);
            lkp_req_i   = ($urandom_range(0, 9) < (((c / 400) % 2) ? 9 : 5));
            lkp_pc_i    = $urandom;
            upd_valid_i = $urandom_range(0, 1);
            upd_pc_i    = (32'($urandom_range(0, 3)) << (IW + 2)) |
                          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            upd_target_i = $urandom;
            upd_taken_i  = $urandom_range(0, 1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_port_sched.md
Name: btb_port_sched

Overview:
- Schedules the single read/write port of the branch target buffer (BTB) table.
- Fetch-stage lookups share the port with branch-resolution updates from the MEM stage. Updates are buffered in a small index-coalescing queue.
- Runs a full-table clear sweep after reset and on flush.
- Sits between the IF/MEM pipeline stages and the BTB storage array. Implements one-bit prediction: the stored taken bit equals the last resolved outcome.

Parameters:
- IDX_W, 6, table index width; the table holds 2^IDX_W entries; index = pc[IDX_W+1:2].
- QDEPTH, 4, update queue depth (power of two, minimum 2).
- STARVE_MAX, 8, number of consecutive lookup grants allowed while the queue is non-empty before one update is forced.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  one-cycle pulse; empties the queue and starts a clear sweep.
- lkp_req_i  in  1  fetch lookup request.
- lkp_pc_i  in  32  fetch PC.
- lkp_gnt_o  out  1  lookup owns the port this cycle.
- lkp_rvalid_o  out  1  table read data valid; lkp_gnt_o delayed one cycle.
- upd_valid_i  in  1  resolved-branch update valid.
- upd_pc_i  in  32  branch PC.
- upd_target_i  in  32  resolved target.
- upd_taken_i  in  1  resolved direction.
- upd_ready_o  out  1  queue can accept an update.
- busy_o  out  1  clear sweep in progress.
- tbl_en_o  out  1  table port enable.
- tbl_we_o  out  1  table write enable.
- tbl_addr_o  out  IDX_W  table address.
- tbl_wdata_o  out  2+TAG_W+32  entry {valid, taken, tag, target}; TAG_W = 30-IDX_W.

Behaviour:
- Reset: while rst_i=1, every output is forced to 0.
  - First cycle after reset release: state CLEAR, sweep address 0.
  - Queue empty; starve counter 0; lkp_rvalid_o register 0.
- FSM CLEAR:
  - Each cycle: tbl_en_o=1, tbl_we_o=1, tbl_addr_o=sweep counter, tbl_wdata_o=0, busy_o=1.
  - lkp_gnt_o=0 and upd_ready_o=0.
  - After address 2^IDX_W-1 is written, go to RUN. A full sweep takes exactly 2^IDX_W cycles.
  - flush_i during CLEAR restarts the counter at 0.
- FSM RUN, arbitration per cycle (combinational outputs):
  - Lookup wins if lkp_req_i=1 and starve_cnt<STARVE_MAX.
    - tbl_en_o=1, tbl_we_o=0, tbl_addr_o=lkp_pc_i[IDX_W+1:2], lkp_gnt_o=1.
  - Otherwise, if the queue is non-empty: write the head entry and pop it.
    - tbl_wdata_o = {1, taken, pc[31:IDX_W+2], target}.
  - Otherwise tbl_en_o=0.
- Starve counter:
  - Increments on a lookup grant while the queue is non-empty.
  - Clears on any write, when the queue is empty, or on flush.
  - Saturates at STARVE_MAX.
- flush_i in RUN: next state CLEAR, queue emptied, sweep counter 0. A flush-cycle grant/write still completes.
- Queue:
  - Push when upd_valid_i && upd_ready_o. upd_ready_o = RUN && !full.
  - When full, ready stays 0 even if a pop occurs in the same cycle (no pass-through).
  - A pushed entry is never written in its push cycle; minimum latency is 1 cycle.
- Coalescing:
  - On push, if a resident entry with the same index exists and is not being popped this cycle, overwrite it in place (pc, target, taken); occupancy is unchanged.
  - If the only match is the head being popped, append a new entry instead.
  - Order is preserved otherwise.
- Simultaneous push and pop on a non-full queue: both take effect; occupancy is unchanged.
- Pointers wrap modulo QDEPTH; full/empty are tracked with an extra pointer bit.

Optional Feature:
- Macro BTB_SCHED_STATS_EN.
- Defined: adds ports wr_cnt_o[31:0] (update writes), stall_cnt_o[31:0] (cycles with lkp_req_i=1 and lkp_gnt_o=0), and coal_cnt_o[31:0] (coalesced pushes).
  - Counters are zeroed by rst_i only, are not affected by flush_i, and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package btb_pkg: IDX_W default, TAG_W derivation, btb_entry_t packed struct {valid, taken, tag, target}, upd_req_t struct {pc, target, taken}, and state enum {CLEAR, RUN}.
- Sub-module btb_upd_fifo: QDEPTH coalescing queue with push/pop/full/empty and index-match overwrite.
- Arbitration, FSM and starve counter stay in btb_port_sched.

Test Plan:
- Reset release → busy_o=1 for 64 cycles; writes to addresses 0..63 with wdata 0; lkp_req_i=1 is not granted during the sweep; RUN follows on cycle 65.
- RUN, no lookups: push pc=0x0000_0104, target=0x200, taken=1 → next cycle tbl_we_o=1, addr=0x01, wdata={1,1,0x000001,0x200}.
- Continuous lkp_req_i with one queued update → exactly 8 lookup grants, then 1 write, then lookups resume; lkp_rvalid_o follows each grant by 1 cycle.
- Two pushes to pc 0x104 then 0x504 (same index, different tags) while lookups block → one queue entry, final write carries tag 0x000005; coal_cnt_o=1 if BTB_SCHED_STATS_EN.
- Fill 4 distinct indices while blocked → upd_ready_o=0; a 5th upd_valid_i is held until a pop frees a slot, with no loss.
- flush_i with 3 entries queued → queue empty, busy_o=1 on the next cycle, and 64 clear writes follow; none of the 3 entries is ever written.
